q_sys_in_port_arbiter: RTL and testbench
========================================

# q_sys_in_port_arbiter

Round-robin arbiter and handshake sequencer that shares the Avalon input PIO between several hardware result producers (e.g. error-correcting arithmetic units). It accepts one 32-bit result at a time, holds it stable on the PIO data input together with a status word on a second PIO, and waits for the Nios II to acknowledge via a toggle bit on an output PIO before granting the next requester. A hold timeout discards an unacknowledged result and raises a sticky flag and interrupt.

## Interface
- NUM_REQ, 4, number of requesters, 2..16
- DATA_W, 32, requester data width
- TIMEOUT, 65535, HOLD cycles before discard; 0 disables the timeout
- clk  in  1  system clock; PIOs and CPU share it
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  requester i has data
- req_data  in  NUM_REQ*DATA_W  requester i data at [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-cycle one-hot accept pulse
- ack_in  in  1  CPU acknowledge toggle from output PIO bit
- in_port_data  out  DATA_W  held result, drives data PIO in_port
- in_port_status  out  32  status word, drives status PIO in_port
- timeout_irq  out  1  level, equals the timeout flag

## Operation
- States: IDLE, HOLD.
- Status word: bit31 valid; bit30 timeout flag; bits29:24 zero; bits23:16 grant index; bits15:0 sequence number.
- IDLE: if any req_valid, select the first asserted index searching from (last_grant+1) mod NUM_REQ upward with wrap. On selection, capture req_data[i], set valid, grant index=i, seq=seq+1 (16-bit wrap 0xFFFF->0x0000), last_grant=i, pulse req_ready[i], enter HOLD, clear timeout counter.
- HOLD: ignore req_valid. Ack event (ack_in != ack_q) -> clear valid, enter IDLE. Otherwise increment the timeout counter. If TIMEOUT!=0 and the counter reaches TIMEOUT -> clear valid, set timeout flag, enter IDLE. The data is discarded, and in_port_data keeps its last value.
- Ack event and timeout in the same cycle: the ack wins and the flag is not set.
- Any ack event (either state) clears the timeout flag. An ack event in IDLE has no other effect.
- ack_q is a register updated to ack_in every cycle.
- Requester contract: hold req_valid and req_data stable until req_ready is seen, then deassert req_valid on the following cycle.

## Timing
- Reset values: state IDLE, in_port_data 0, in_port_status 0, req_ready 0, timeout_irq 0, ack_q 0, seq 0, last_grant NUM_REQ-1 (requester 0 has first priority), counter 0.
- All outputs are registered.
- Grant latency: req_valid sampled high in IDLE at edge T -> req_ready, data, and status updated after edge T (visible in cycle T+1).
- Ack latency: ack_in toggles before edge T -> valid=0 and IDLE after T. The earliest next grant samples at edge T+1, so there is a minimum of 1 IDLE cycle between grants.
- Timeout: valid drops exactly TIMEOUT cycles after the grant cycle.
- Reset mid-HOLD: the held result is lost, all state returns to reset values, and the CPU-side output PIO also resets ack to 0.

## Test plan
- Single requester: req_valid[2]=1, data 0xDEADBEEF -> one req_ready[2] pulse; status 0x8002_0001; data PIO 0xDEADBEEF; ack toggle -> status 0x0002_0001.
- Round robin: all four requesters held valid and re-asserted after each ack -> grant order 0,1,2,3,0 with seq 1..5.
- Timeout with TIMEOUT=8: grant then no ack -> valid clears 8 cycles after the grant, bit30 and timeout_irq go high; a later ack toggle clears both.
- Ack and timeout coincident: ack toggle timed to land on the expiry cycle -> valid clears, flag stays 0.
- Sequence wrap: force 65536 grants (or preload in simulation) -> seq goes 0xFFFF then 0x0000.
- Reset asserted during HOLD -> all outputs 0 asynchronously; after release, requester 0 wins over simultaneous 0 and 3.

Source files
------------

// File: rtl/q_sys_in_port_arbiter.sv
// Round-robin arbiter that hands one requester result at a time to the Nios II input PIOs.
// Latency: grant visible one cycle after req_valid is sampled in IDLE; release one cycle after an ack toggle.
// Backpressure: req_ready pulses once per accepted result; requesters wait in HOLD until ack or timeout.
module q_sys_in_port_arbiter #(
    parameter int          NUM_REQ  = 4,
    parameter int          DATA_W   = 32,
    parameter int          TIMEOUT  = 65535,
    parameter logic [15:0] SEQ_INIT = 16'h0000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        ack_in,
    output logic [DATA_W-1:0]           in_port_data,
    output logic [31:0]                 in_port_status,
    output logic                        timeout_irq
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 tflag_q, tflag_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [15:0]          seq_q, seq_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   ready_q, ready_d;
    logic                 ack_q;
    logic                 ack_ev;

    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    int                   cand;

    assign ack_ev = (ack_in != ack_q);

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!sel_found && req_valid[IDX_W'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        tflag_d = tflag_q;
        idx_d   = idx_q;
        last_d  = last_q;
        seq_d   = seq_q;
        cnt_d   = cnt_q;
        ready_d = '0;
        if (ack_ev) tflag_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    data_d  = req_data[sel_idx*DATA_W +: DATA_W];
                    idx_d   = sel_idx;
                    last_d  = sel_idx;
                    seq_d   = seq_q + 16'd1;
                    ready_d = NUM_REQ'(1) << sel_idx;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ack_ev) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    // Expiry drops the result but leaves the data PIO showing it.
                    if (TIMEOUT != 0 && cnt_d == 32'(TIMEOUT)) begin
                        tflag_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            tflag_q <= 1'b0;
            idx_q   <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            seq_q   <= SEQ_INIT;
            cnt_q   <= '0;
            ready_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            tflag_q <= tflag_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            seq_q   <= seq_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            ack_q   <= ack_in;
        end
    end

    assign req_ready      = ready_q;
    assign in_port_data   = data_q;
    assign in_port_status = {state_q == HOLD, tflag_q, 6'b0, 8'(idx_q), seq_q};
    assign timeout_irq    = tflag_q;

endmodule

// File: tb/tb_q_sys_in_port_arbiter.sv
// Bench for q_sys_in_port_arbiter: directed table, hand sequences, and random traffic against a reference model.
module tb_q_sys_in_port_arbiter;

    localparam int TMO = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   rv;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         ack;
    logic [31:0]  in_port_data;
    logic [31:0]  in_port_status;
    logic         timeout_irq;
    logic [31:0]  rd [4];

    logic [1:0]   w_rv;
    logic [15:0]  w_rd;
    logic [1:0]   w_rdy;
    logic         w_ack;
    logic [7:0]   w_data;
    logic [31:0]  w_status;
    logic         w_irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = rd[i];
    end

    q_sys_in_port_arbiter #(.NUM_REQ(4), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(rv), .req_data(req_data),
        .req_ready(req_ready), .ack_in(ack), .in_port_data(in_port_data),
        .in_port_status(in_port_status), .timeout_irq(timeout_irq)
    );

    q_sys_in_port_arbiter #(.NUM_REQ(2), .DATA_W(8), .TIMEOUT(0), .SEQ_INIT(16'hFFFE)) dut_w (
        .clk(clk), .reset_n(reset_n), .req_valid(w_rv), .req_data(w_rd),
        .req_ready(w_rdy), .ack_in(w_ack), .in_port_data(w_data),
        .in_port_status(w_status), .timeout_irq(w_irq)
    );

    typedef struct {
        logic [3:0]  rv;
        logic        ack;
        logic [3:0]  rdy;
        logic [31:0] st;
        logic [31:0] dat;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ack     = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    // Reference model state: cycle-indexed, not counter based.
    logic        m_hold, m_flag, m_ackq, ev, got;
    logic [3:0]  m_rdy;
    logic [31:0] m_data;
    int          m_idx, m_last, m_seq, m_gcyc, j;

    initial begin
        rd[0] = 32'h1111_0000; rd[1] = 32'h2222_0001;
        rd[2] = 32'hDEAD_BEEF; rd[3] = 32'h4444_0003;
        rv = '0; ack = 1'b0; reset_n = 1'b0;
        w_rv = '0; w_ack = 1'b0; w_rd = 16'hB7A5;

        tbl[0] = '{4'b1111, 1'b0, 4'b0001, 32'h8000_0001, 32'h1111_0000};
        tbl[1] = '{4'b1110, 1'b1, 4'b0000, 32'h0000_0001, 32'h1111_0000};
        tbl[2] = '{4'b1111, 1'b1, 4'b0010, 32'h8001_0002, 32'h2222_0001};
        tbl[3] = '{4'b1101, 1'b0, 4'b0000, 32'h0001_0002, 32'h2222_0001};
        tbl[4] = '{4'b1111, 1'b0, 4'b0100, 32'h8002_0003, 32'hDEAD_BEEF};
        tbl[5] = '{4'b1011, 1'b1, 4'b0000, 32'h0002_0003, 32'hDEAD_BEEF};
        tbl[6] = '{4'b1111, 1'b1, 4'b1000, 32'h8003_0004, 32'h4444_0003};
        tbl[7] = '{4'b0111, 1'b0, 4'b0000, 32'h0003_0004, 32'h4444_0003};
        tbl[8] = '{4'b1111, 1'b0, 4'b0001, 32'h8000_0005, 32'h1111_0000};
        tbl[9] = '{4'b1110, 1'b1, 4'b0000, 32'h0000_0005, 32'h1111_0000};

        repeat (2) @(negedge clk);
        chk("reset_status", in_port_status, 32'h0);
        chk("reset_data", in_port_data, 32'h0);
        chk("reset_rdy", 32'(req_ready), 32'h0);
        chk("reset_irq", 32'(timeout_irq), 32'h0);
        reset_n = 1'b1;

        // Single requester
        rv = 4'b0100; step();
        chk("single_rdy", 32'(req_ready), 32'h4);
        chk("single_status", in_port_status, 32'h8002_0001);
        chk("single_data", in_port_data, 32'hDEAD_BEEF);
        rv = 4'b0000; step();
        chk("single_rdy_pulse", 32'(req_ready), 32'h0);
        ack = 1'b1; step();
        chk("single_ack_status", in_port_status, 32'h0002_0001);
        chk("single_ack_data", in_port_data, 32'hDEAD_BEEF);

        // Round robin from reset
        do_reset();
        for (int r = 0; r < 10; r++) begin
            rv = tbl[r].rv; ack = tbl[r].ack; step();
            chk($sformatf("rr%0d_rdy", r), 32'(req_ready), 32'(tbl[r].rdy));
            chk($sformatf("rr%0d_status", r), in_port_status, tbl[r].st);
            chk($sformatf("rr%0d_data", r), in_port_data, tbl[r].dat);
        end

        // Timeout: valid drops exactly TMO cycles after the grant
        rv = 4'b0010; step();
        chk("tmo_grant", in_port_status, 32'h8001_0006);
        rv = 4'b0000;
        repeat (TMO - 1) step();
        chk("tmo_still_valid", in_port_status, 32'h8001_0006);
        step();
        chk("tmo_expired", in_port_status, 32'h4001_0006);
        chk("tmo_irq", 32'(timeout_irq), 32'h1);
        chk("tmo_data_kept", in_port_data, 32'h2222_0001);
        ack = 1'b0; step();
        chk("tmo_ack_clear", in_port_status, 32'h0001_0006);
        chk("tmo_irq_clear", 32'(timeout_irq), 32'h0);

        // Ack landing on the expiry edge wins
        rv = 4'b0100; step();
        chk("coinc_grant", in_port_status, 32'h8002_0007);
        rv = 4'b0000;
        repeat (TMO - 1) step();
        ack = 1'b1; step();
        chk("coinc_status", in_port_status, 32'h0002_0007);
        chk("coinc_irq", 32'(timeout_irq), 32'h0);

        // Random traffic versus model
        rv = '0;
        do_reset();
        m_hold = 0; m_flag = 0; m_ackq = 0; m_rdy = '0; m_data = '0;
        m_idx = 0; m_last = 3; m_seq = 0; m_gcyc = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (m_rdy[i]) rv[i] = 1'b0;
                else if (!rv[i] && $urandom_range(3) == 0) begin
                    rv[i] = 1'b1;
                    rd[i] = $urandom;
                end
            end
            if ($urandom_range(9) == 0) ack = ~ack;
            ev = (ack != m_ackq);
            m_rdy = '0;
            if (ev) m_flag = 1'b0;
            if (!m_hold) begin
                got = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    j = (m_last + k) % 4;
                    if (!got && rv[2'(j)]) begin
                        got = 1'b1;
                        m_hold = 1'b1; m_idx = j; m_last = j;
                        m_seq = (m_seq + 1) % 65536;
                        m_data = rd[j]; m_rdy[2'(j)] = 1'b1; m_gcyc = c;
                    end
                end
            end else if (ev) begin
                m_hold = 1'b0;
            end else if (c - m_gcyc == TMO) begin
                m_hold = 1'b0; m_flag = 1'b1;
            end
            m_ackq = ack;
            step();
            chk("rnd_rdy", 32'(req_ready), 32'(m_rdy));
            chk("rnd_data", in_port_data, m_data);
            chk("rnd_status", in_port_status, {m_hold, m_flag, 6'b0, 8'(m_idx), 16'(m_seq)});
            chk("rnd_irq", 32'(timeout_irq), 32'(m_flag));
        end

        // Reset during HOLD
        rv = 4'b0000; ack = ~ack; step();
        rv = 4'b0001; step();
        chk("rst_hold_valid", 32'(in_port_status[31]), 32'h1);
        #2;
        reset_n = 1'b0; ack = 1'b0;
        #1;
        chk("rst_async_status", in_port_status, 32'h0);
        chk("rst_async_data", in_port_data, 32'h0);
        chk("rst_async_rdy", 32'(req_ready), 32'h0);
        chk("rst_async_irq", 32'(timeout_irq), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rv = 4'b1001; step();
        chk("rst_prio_rdy", 32'(req_ready), 32'h1);
        chk("rst_prio_status", in_port_status, 32'h8000_0001);
        chk("rst_prio_data", in_port_data, rd[0]);
        rv = 4'b1000; step();

        // Sequence wrap and disabled timeout on the second instance
        w_rv = 2'b01; step();
        chk("wrap_ffff", w_status, 32'h8000_FFFF);
        chk("wrap_data0", 32'(w_data), 32'hA5);
        w_rv = 2'b00;
        repeat (20) step();
        chk("notmo_hold", w_status, 32'h8000_FFFF);
        chk("notmo_irq", 32'(w_irq), 32'h0);
        w_ack = 1'b1; step();
        chk("wrap_ack", w_status, 32'h0000_FFFF);
        w_rv = 2'b11; step();
        chk("wrap_0000", w_status, 32'h8001_0000);
        chk("wrap_rdy", 32'(w_rdy), 32'h2);
        chk("wrap_data1", 32'(w_data), 32'hB7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
